// File: rtl/fire_mode_icon_renderer_pkg.sv
// rtl/fire_mode_icon_renderer_pkg.sv - shared pixel codes, colours and fire-mode encodings for the icon renderer
package fire_mode_icon_renderer_pkg;

    // Sprite geometry is fixed by the memory layout (48*24 = 1152 words)
    localparam int ICON_W = 48;
    localparam int ICON_H = 24;

    typedef enum logic [1:0] {
        PIX_TRANSPARENT = 2'b00,
        PIX_WHITE       = 2'b01,
        PIX_GOLD        = 2'b10,
        PIX_RED         = 2'b11
    } pix_code_e;

    localparam logic [23:0] RGB_TRANSPARENT = 24'h000000;
    localparam logic [23:0] RGB_WHITE       = 24'hFFFFFF;
    localparam logic [23:0] RGB_GOLD        = 24'hFFD700;
    localparam logic [23:0] RGB_RED         = 24'hFF2020;

    // Shared with sprite memory and game logic; codes 2 and 3 both show one bullet
    typedef enum logic [1:0] {
        FIRE_THREE   = 2'd0,
        FIRE_FIVE    = 2'd1,
        FIRE_ONE     = 2'd2,
        FIRE_ONE_ALT = 2'd3
    } fire_mode_e;

    function automatic logic [23:0] pix_to_rgb(input logic [1:0] code);
        logic [23:0] rgb;
        case (code)
            PIX_WHITE: rgb = RGB_WHITE;
            PIX_GOLD:  rgb = RGB_GOLD;
            PIX_RED:   rgb = RGB_RED;
            default:   rgb = RGB_TRANSPARENT;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/fire_mode_icon_renderer_flash_ctrl.sv
// rtl/fire_mode_icon_renderer_flash_ctrl.sv - frame-synchronous displayed-mode latch, flash counter and blink phase
module icon_flash_ctrl #(
    parameter int FLASH_FRAMES = 60,
    parameter int BLINK_HALF   = 8,
    parameter int FLASH_W      = $clog2(FLASH_FRAMES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_frame_start,
    input  logic [1:0]         i_fire_mode_req,
    output logic [1:0]         o_disp_mode,
    output logic [FLASH_W-1:0] o_flash_cnt,
    output logic               o_blink_off
);

    localparam int               LP_BLINK_BIT = $clog2(BLINK_HALF);
    localparam logic [FLASH_W-1:0] LP_FLASH_LOAD = FLASH_W'(FLASH_FRAMES);

    logic [1:0]         r_disp_mode;
    logic [FLASH_W-1:0] r_flash_cnt;

    // Mode and flash counter only move at frame boundaries so the icon never tears mid-frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_disp_mode <= 2'd0;
            r_flash_cnt <= '0;
        end else if (i_frame_start) begin
            r_disp_mode <= i_fire_mode_req;
            if (i_fire_mode_req != r_disp_mode) begin
                r_flash_cnt <= LP_FLASH_LOAD;
            end else if (r_flash_cnt != '0) begin
                r_flash_cnt <= r_flash_cnt - 1'b1;
            end
        end
    end

    assign o_disp_mode = r_disp_mode;
    assign o_flash_cnt = r_flash_cnt;
    assign o_blink_off = (r_flash_cnt != '0) && r_flash_cnt[LP_BLINK_BIT];

endmodule

// File: rtl/fire_mode_icon_renderer.sv
// rtl/fire_mode_icon_renderer.sv - beam-to-sprite address generator and 3-stage pixel colour pipeline for the fire-mode icon
module fire_mode_icon_renderer
    import fire_mode_icon_renderer_pkg::*;
#(
    parameter logic [9:0] ICON_X       = 10'd576,
    parameter logic [9:0] ICON_Y       = 10'd8,
    parameter int         FLASH_FRAMES = 60,
    parameter int         BLINK_HALF   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    input  logic        video_on,
    input  logic        frame_start,
    input  logic [1:0]  fire_mode_req,
    output logic [1:0]  mem_fire_mode,
    output logic [10:0] mem_address,
    input  logic [1:0]  mem_pixel_data,
    output logic [23:0] icon_rgb,
    output logic        icon_opaque
);

    localparam logic [9:0] LP_X_END = ICON_X + 10'(ICON_W);
    localparam logic [9:0] LP_Y_END = ICON_Y + 10'(ICON_H);
    localparam int         LP_FLASH_W = $clog2(FLASH_FRAMES + 1);

    logic [1:0]            w_disp_mode;
    logic [LP_FLASH_W-1:0] w_flash_cnt;
    logic                  w_blink_off;
    logic                  w_in_box;
    logic [9:0]            w_dx;
    logic [9:0]            w_dy;
    logic [10:0]           w_dy11;
    logic [10:0]           w_addr;

    logic [10:0] r_mem_address;
    logic        r_v0;
    logic        r_v1;
    logic [23:0] r_icon_rgb;
    logic        r_icon_opaque;

    icon_flash_ctrl #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .BLINK_HALF   (BLINK_HALF),
        .FLASH_W      (LP_FLASH_W)
    ) u_flash (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_frame_start   (frame_start),
        .i_fire_mode_req (fire_mode_req),
        .o_disp_mode     (w_disp_mode),
        .o_flash_cnt     (w_flash_cnt),
        .o_blink_off     (w_blink_off)
    );

    assign w_in_box = video_on
                   && (h_count >= ICON_X) && (h_count < LP_X_END)
                   && (v_count >= ICON_Y) && (v_count < LP_Y_END);
    assign w_dx   = h_count - ICON_X;
    assign w_dy   = v_count - ICON_Y;
    assign w_dy11 = {1'b0, w_dy};
    // dy*48 as two shifts; row stride is fixed by the sprite memory layout
    assign w_addr = (w_dy11 << 5) + (w_dy11 << 4) + {1'b0, w_dx};

    // Stage 0: register the sprite address; out-of-box beams park the address at 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_address <= 11'd0;
            r_v0          <= 1'b0;
        end else begin
            r_mem_address <= w_in_box ? w_addr : 11'd0;
            r_v0          <= w_in_box;
        end
    end

    // Stage 1: track validity while the memory performs its registered read; blink hides the icon here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= r_v0 & ~w_blink_off;
        end
    end

    // Stage 2: map the returned pixel code to colour and opacity
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_icon_rgb    <= 24'd0;
            r_icon_opaque <= 1'b0;
        end else begin
            r_icon_opaque <= r_v1 && (mem_pixel_data != PIX_TRANSPARENT);
            r_icon_rgb    <= r_v1 ? pix_to_rgb(mem_pixel_data) : RGB_TRANSPARENT;
        end
    end

    assign mem_fire_mode = w_disp_mode;
    assign mem_address   = r_mem_address;
    assign icon_rgb      = r_icon_rgb;
    assign icon_opaque   = r_icon_opaque;

endmodule

// File: tb/tb_fire_mode_icon_renderer.sv
// tb/tb_fire_mode_icon_renderer.sv - directed self-checking bench for fire_mode_icon_renderer
module tb_fire_mode_icon_renderer;

    localparam logic [9:0] IX = 10'd576;
    localparam logic [9:0] IY = 10'd8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        video_on;
    logic        frame_start;
    logic [1:0]  fire_mode_req;
    logic [1:0]  mem_fire_mode;
    logic [10:0] mem_address;
    logic [1:0]  mem_pixel_data = 2'b00;
    logic [23:0] icon_rgb;
    logic        icon_opaque;

    int n_cmp = 0;
    int n_err = 0;

    fire_mode_icon_renderer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .h_count        (h_count),
        .v_count        (v_count),
        .video_on       (video_on),
        .frame_start    (frame_start),
        .fire_mode_req  (fire_mode_req),
        .mem_fire_mode  (mem_fire_mode),
        .mem_address    (mem_address),
        .mem_pixel_data (mem_pixel_data),
        .icon_rgb       (icon_rgb),
        .icon_opaque    (icon_opaque)
    );

    always #5 clk = ~clk;

    // Sprite memory model: registered read, pixel code = low two address bits
    always @(posedge clk) mem_pixel_data <= mem_address[1:0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic beam(input logic [9:0] h, input logic [9:0] v, input logic von);
        h_count  = h;
        v_count  = v;
        video_on = von;
    endtask

    logic [1:0]  codes [4];
    logic [23:0] rgbs  [4];

    initial begin
        codes[0] = 2'b01; rgbs[0] = 24'hFFFFFF;
        codes[1] = 2'b10; rgbs[1] = 24'hFFD700;
        codes[2] = 2'b11; rgbs[2] = 24'hFF2020;
        codes[3] = 2'b00; rgbs[3] = 24'h000000;

        rst_n = 1'b0; frame_start = 1'b0; fire_mode_req = 2'd0;
        beam(10'd0, 10'd0, 1'b0);
        step(); step();
        check("rst_mode",   32'(mem_fire_mode), 32'd0);
        check("rst_addr",   32'(mem_address),   32'd0);
        check("rst_rgb",    32'(icon_rgb),      32'd0);
        check("rst_opaque", 32'(icon_opaque),   32'd0);
        check("rst_flash",  32'(dut.u_flash.o_flash_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // First row sweep: address follows dx one cycle later, opacity two iterations behind
        for (int i = 0; i < 48; i++) begin
            beam(IX + 10'(i), IY, 1'b1);
            step();
            check("sweep_addr", 32'(mem_address), 32'(i));
            if (i >= 2) check("sweep_opq", 32'(icon_opaque), ((i - 2) % 4 != 0) ? 32'd1 : 32'd0);
        end
        beam(10'd0, 10'd0, 1'b0);
        step(); check("sweep_opq46", 32'(icon_opaque), 32'd1);
        step(); check("sweep_opq47", 32'(icon_opaque), 32'd1);

        // Corner and right-edge boundaries
        beam(IX + 10'd47, IY + 10'd23, 1'b1);
        step(); check("corner_addr", 32'(mem_address), 32'd1151);
        beam(IX + 10'd48, IY, 1'b1);
        step(); check("edge_addr", 32'(mem_address), 32'd0);
        step(); check("corner_opq", 32'(icon_opaque), 32'd1);
                check("corner_rgb", 32'(icon_rgb),    32'hFF2020);
        step(); check("edge_opq",   32'(icon_opaque), 32'd0);

        // Colour LUT
        for (int k = 0; k < 4; k++) begin
            beam(IX + 10'(codes[k]), IY + 10'd1, 1'b1);
            step(); step(); step();
            check("lut_rgb", 32'(icon_rgb),    32'(rgbs[k]));
            check("lut_opq", 32'(icon_opaque), (k == 3) ? 32'd0 : 32'd1);
        end

        // video_on low inside the box
        beam(IX + 10'd1, IY, 1'b0);
        step(); step(); step();
        check("vid_off_opq", 32'(icon_opaque), 32'd0);
        check("vid_off_rgb", 32'(icon_rgb),    32'd0);

        // Mid-frame request is ignored until frame_start, which then starts a flash
        fire_mode_req = 2'd1;
        step(); step();
        check("midframe_mode", 32'(mem_fire_mode), 32'd0);
        frame_pulse();
        check("latch_mode",  32'(mem_fire_mode), 32'd1);
        check("flash_load",  32'(dut.u_flash.o_flash_cnt), 32'd60);
        check("blink_on",    32'(dut.u_flash.o_blink_off), 32'd1);
        beam(IX + 10'd1, IY, 1'b1);
        step(); step(); step();
        check("hidden_opq", 32'(icon_opaque), 32'd0);
        frame_pulse();
        check("flash_dec", 32'(dut.u_flash.o_flash_cnt), 32'd59);
        for (int f = 0; f < 4; f++) frame_pulse();
        check("flash_55",  32'(dut.u_flash.o_flash_cnt), 32'd55);
        check("blink_55",  32'(dut.u_flash.o_blink_off), 32'd0);
        step(); step(); step();
        check("shown_opq", 32'(icon_opaque), 32'd1);

        // Reload during an active flash
        for (int f = 0; f < 35; f++) frame_pulse();
        check("flash_20", 32'(dut.u_flash.o_flash_cnt), 32'd20);
        fire_mode_req = 2'd2;
        frame_pulse();
        check("reload_cnt",  32'(dut.u_flash.o_flash_cnt), 32'd60);
        check("reload_mode", 32'(mem_fire_mode), 32'd2);

        // Get back to a visible phase, then reset mid-line with the beam in the box
        for (int f = 0; f < 5; f++) frame_pulse();
        step(); step(); step();
        check("pre_rst_opq", 32'(icon_opaque), 32'd1);
        rst_n = 1'b0;
        step();
        check("mrst_opq",   32'(icon_opaque), 32'd0);
        check("mrst_rgb",   32'(icon_rgb),    32'd0);
        check("mrst_mode",  32'(mem_fire_mode), 32'd0);
        check("mrst_flash", 32'(dut.u_flash.o_flash_cnt), 32'd0);
        check("mrst_addr",  32'(mem_address), 32'd0);
        rst_n = 1'b1;
        fire_mode_req = 2'd0;
        step();
        frame_pulse();
        check("mode0_noflash", 32'(dut.u_flash.o_flash_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fire_mode_icon_renderer.md
Name: fire_mode_icon_renderer

Overview:
Drives the address side of the fire-mode icon sprite memory (three/five/one-bullet icons, 48x24 pixels, 2-bit pixels). It also consumes the returned pixel data. It turns VGA beam coordinates into sprite addresses and compensates for the memory's one-cycle registered read. It maps 2-bit pixel codes to 24-bit RGB with a transparency flag for the final pixel mux. Icon changes are frame-synchronous, and the icon blinks briefly after each fire-mode change.

Parameters:
ICON_X, 10'd576, left column of icon box (beam h_count coordinate)
ICON_Y, 10'd8, top row of icon box (beam v_count coordinate)
ICON_W, 48, icon width in pixels (fixed by memory layout; 48*24 = 1152 words)
ICON_H, 24, icon height in pixels
FLASH_FRAMES, 60, number of frames the icon blinks after a mode change
BLINK_HALF, 8, frames per blink half-period

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  synchronous active-low reset
h_count  in  10  current beam column
v_count  in  10  current beam row
video_on  in  1  beam inside visible area
frame_start  in  1  one-cycle pulse at start of each frame (before first visible line)
fire_mode_req  in  2  fire mode currently selected by game logic
mem_fire_mode  out  2  icon select to sprite memory
mem_address  out  11  sprite word address to memory
mem_pixel_data  in  2  registered memory read data, valid one cycle after mem_address
icon_rgb  out  24  {R[7:0],G[7:0],B[7:0]} icon colour
icon_opaque  out  1  1 = pixel mux selects icon_rgb over background

Behaviour:
- Reset (rst_n=0 at a clk edge): mem_fire_mode=0, mem_address=0, icon_rgb=0, icon_opaque=0, flash counter=0, pipeline valid flags=0. The displayed mode register resets to 0, so after reset a mode-0 request causes no flash.
- Mode latch: the displayed mode register loads fire_mode_req only on cycles with frame_start=1. Mid-frame changes of fire_mode_req have no effect until the next frame_start. mem_fire_mode = displayed mode register.
- Flash: when frame_start=1 and fire_mode_req differs from the displayed mode, flash counter loads FLASH_FRAMES. Otherwise it decrements once per frame_start while nonzero. A new change during an active flash reloads the counter.
- Blink phase: blink_off = (flash counter != 0) and bit log2(BLINK_HALF) of flash counter = 1. This gives 8 frames hidden, then 8 frames shown.
- Stage 0 (registered): in_box = video_on and ICON_X <= h_count < ICON_X+ICON_W and ICON_Y <= v_count < ICON_Y+ICON_H.
  - When in_box: mem_address <= (v_count-ICON_Y)*48 + (h_count-ICON_X), computed as (dy<<5)+(dy<<4)+dx, truncated to 11 bits (maximum is 1151).
  - When not in_box: mem_address <= 0.
  - v0 <= in_box.
- Stage 1: the memory returns data for the stage-0 address. v1 <= v0 & ~blink_off.
- Stage 2 (registered outputs): icon_opaque <= v1 & (mem_pixel_data != 0). icon_rgb is set as follows:
  - 00: 0 (transparent)
  - 01: 24'hFFFFFF
  - 10: 24'hFFD700
  - 11: 24'hFF2020
  - When v1=0: icon_rgb <= 0.
- Latency: 3 clk from beam coordinate to icon_rgb/icon_opaque. The VGA top level delays background/sync by 3 to align.
- Boundaries:
  - h_count = ICON_X+47, v_count = ICON_Y+23 gives address 1151.
  - h_count = ICON_X+48 gives in_box=0.
  - video_on=0 inside the box gives opaque=0.
  - A frame_start coinciding with an in-box pixel is harmless, because the mode changes between frames.
  - Reset mid-line flushes the pipeline; outputs are 0 the next cycle.

Decomposition:
- Shared package/header: 2-bit pixel code constants (PIX_TRANSPARENT, PIX_WHITE, PIX_GOLD, PIX_RED) and their RGB values.
- The same package holds the fire-mode encodings (0=three, 1=five, 2/3=one bullet), shared with the sprite memory and game logic.
- One natural sub-module: icon_flash_ctrl. It owns the displayed-mode latch, flash counter and blink_off, is driven by frame_start/fire_mode_req, and is testable standalone.
- Address generator and colour LUT stay inline.

Test Plan:
- Reset, then sweep h=ICON_X..ICON_X+47, v=ICON_Y with video_on=1 -> mem_address = 0..47 in successive cycles; icon_opaque tracks a memory model's nonzero pixels 3 cycles later.
- Beam at (ICON_X+47, ICON_Y+23) -> mem_address=1151. Beam at (ICON_X+48, ICON_Y) -> icon_opaque=0 three cycles later and mem_address=0.
- Memory model returns 01/10/11/00 -> icon_rgb = FFFFFF/FFD700/FF2020/000000 with opaque 1/1/1/0.
- fire_mode_req 0->1 mid-frame -> mem_fire_mode stays 0 until the next frame_start, then becomes 1. The flash counter becomes 60 and the icon is hidden during frames where bit 3 of the counter is 1.
- Mode change 1->2 while the flash counter is 20 -> counter reloads to 60 at that frame_start; mem_fire_mode=2.
- rst_n=0 for one cycle while the beam is in the box -> next cycle icon_opaque=0, icon_rgb=0, mem_fire_mode=0, flash counter=0.
